// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: default widths,
// reset/interrupt addresses and the FSM state encoding.
package pc_seq_pkg;

    localparam int          DEF_ADDR_W     = 16;
    localparam int          DEF_DATA_W     = 16;
    localparam logic [15:0] DEF_RESET_PC   = 16'h0000;
    localparam logic [15:0] DEF_IRQ_VECTOR = 16'h0010;

    typedef logic [2:0] seqState_t;

    localparam seqState_t S_FETCH  = 3'd0;
    localparam seqState_t S_DECODE = 3'd1;
    localparam seqState_t S_EXEC   = 3'd2;
    localparam seqState_t S_HALT   = 3'd3;
    localparam seqState_t S_FAULT  = 3'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection at instruction retirement: halt > irq > branch > increment.
// Purely combinational; increment wraps modulo 2^ADDR_W.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR = ADDR_W'(DEF_IRQ_VECTOR)
) (
    input  logic              halt,
    input  logic              irq,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] nextPc,
    output logic [ADDR_W-1:0] epcLoad,
    output logic              irqTake
);

    logic [ADDR_W-1:0] pcPlusOne;

    assign pcPlusOne = pc + ADDR_W'(1);

    // The interrupt returns to wherever the retiring instruction would have gone.
    assign epcLoad = branchTaken ? branchTarget : pcPlusOne;
    assign irqTake = irq & ~halt;

    always_comb begin
        nextPc = pcPlusOne;
        if (halt)
            nextPc = pcPlusOne;
        else if (irq)
            nextPc = IRQ_VECTOR;
        else if (branchTaken)
            nextPc = branchTarget;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Clocked program-counter controller: fetch handshake with timeout, one-cycle
// decode pulse, and PC update on execDone (halt / irq / branch / increment).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W        = DEF_ADDR_W,
    parameter int                DATA_W        = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC      = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] IRQ_VECTOR    = ADDR_W'(DEF_IRQ_VECTOR),
    parameter int                FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [DATA_W-1:0] imemData,
    output logic              instrValid,
    output logic [DATA_W-1:0] instrOut,
    input  logic              execDone,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              irq,
    output logic              irqAck,
    output logic [ADDR_W-1:0] epc,
    input  logic              halt,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W-1:0] pc
);

    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    seqState_t         state;
    logic [CNT_W-1:0]  timeoutCnt;
    logic [ADDR_W-1:0] nextPc;
    logic [ADDR_W-1:0] epcLoad;
    logic              irqTake;

    pc_next_sel #(
        .ADDR_W     (ADDR_W),
        .IRQ_VECTOR (IRQ_VECTOR)
    ) uNextSel (
        .halt         (halt),
        .irq          (irq),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .pc           (pc),
        .nextPc       (nextPc),
        .epcLoad      (epcLoad),
        .irqTake      (irqTake)
    );

    assign imemAddr = pc;
    assign halted   = (state == S_HALT);
    assign fault    = (state == S_FAULT);

    // imemReq is registered so it stays low through reset; in FETCH it also
    // marks the cycles that actually count against the timeout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            timeoutCnt <= '0;
            epc        <= '0;
            instrOut   <= '0;
            imemReq    <= 1'b0;
            instrValid <= 1'b0;
            irqAck     <= 1'b0;
        end else begin
            instrValid <= 1'b0;
            irqAck     <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!imemReq) begin
                        imemReq <= 1'b1;
                    end else if (imemAck) begin
                        instrOut   <= imemData;
                        instrValid <= 1'b1;
                        imemReq    <= 1'b0;
                        timeoutCnt <= '0;
                        state      <= S_DECODE;
                    end else if (timeoutCnt == CNT_LAST) begin
                        imemReq <= 1'b0;
                        state   <= S_FAULT;
                    end else begin
                        timeoutCnt <= timeoutCnt + CNT_W'(1);
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (execDone) begin
                        pc <= nextPc;
                        if (irqTake) begin
                            epc    <= epcLoad;
                            irqAck <= 1'b1;
                        end
                        if (halt) begin
                            state <= S_HALT;
                        end else begin
                            imemReq <= 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: begin
                    imemReq <= 1'b0;
                    state   <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: memory and execute-stage responders with
// random latencies and ignored-signal noise, checked against a transaction model.
module tb_pc_sequencer;

    localparam int          TO   = 15;
    localparam logic [15:0] IRQV = 16'h0010;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [15:0] imemData = '0;
    logic        instrValid;
    logic [15:0] instrOut;
    logic        execDone = 1'b0;
    logic        branchTaken = 1'b0;
    logic [15:0] branchTarget = '0;
    logic        irq = 1'b0;
    logic        irqAck;
    logic [15:0] epc;
    logic        halt = 1'b0;
    logic        halted;
    logic        fault;
    logic [15:0] pc;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mPc;
    logic [15:0] mEpc;

    pc_sequencer #(
        .ADDR_W        (16),
        .DATA_W        (16),
        .RESET_PC      (16'h0000),
        .IRQ_VECTOR    (IRQV),
        .FETCH_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .instrValid   (instrValid),
        .instrOut     (instrOut),
        .execDone     (execDone),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .irq          (irq),
        .irqAck       (irqAck),
        .epc          (epc),
        .halt         (halt),
        .halted       (halted),
        .fault        (fault),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs;
        imemAck = 1'b0; execDone = 1'b0; irq = 1'b0;
        halt = 1'b0; branchTaken = 1'b0;
    endtask

    // Random values on signals the current state must ignore.
    task automatic noise(input bit ackAllowed, input bit doneAllowed);
        imemAck      = ackAllowed ? 1'($urandom_range(0, 1)) : 1'b0;
        execDone     = doneAllowed ? 1'($urandom_range(0, 1)) : 1'b0;
        irq          = 1'($urandom_range(0, 1));
        halt         = 1'($urandom_range(0, 1));
        branchTaken  = 1'($urandom_range(0, 1));
        branchTarget = 16'($urandom);
    endtask

    task automatic doReset;
        clearInputs();
        reset_n = 1'b0;
        step();
        step();
        checkVal("rstReq", imemReq, 0);
        checkVal("rstPc", pc, 16'h0000);
        checkVal("rstEpc", epc, 0);
        checkVal("rstInstr", instrOut, 0);
        checkVal("rstOuts", {instrValid, irqAck, halted, fault}, 0);
        reset_n = 1'b1;
        mPc  = 16'h0000;
        mEpc = 16'h0000;
    endtask

    task automatic waitReq;
        int n = 0;
        while (!imemReq && n < 4) begin
            step();
            n++;
        end
        checkVal("reqSeen", imemReq, 1);
        checkVal("fetchAddr", imemAddr, mPc);
    endtask

    // One full instruction; ackDelay = request cycles without ack before the ack.
    task automatic runInstr(input int ackDelay, input int execDelay, input logic [15:0] word,
                            input bit br, input logic [15:0] tgt, input bit irqIn, input bit haltIn);
        bit expIrqAck;
        waitReq();
        for (int i = 0; i < ackDelay; i++) begin
            noise(1'b0, 1'b1);
            step();
            checkVal("reqHold", {imemReq, instrValid}, 2'b10);
        end
        noise(1'b0, 1'b1);
        imemAck  = 1'b1;
        imemData = word;
        step();
        noise(1'b1, 1'b1);
        checkVal("decValid", instrValid, 1);
        checkVal("decInstr", instrOut, word);
        checkVal("decReq", imemReq, 0);
        step();
        checkVal("execValid", instrValid, 0);
        for (int i = 0; i < execDelay; i++) begin
            noise(1'b1, 1'b0);
            step();
            checkVal("execWaitPc", pc, mPc);
        end
        clearInputs();
        execDone = 1'b1; halt = haltIn; irq = irqIn;
        branchTaken = br; branchTarget = tgt;
        imemAck = 1'($urandom_range(0, 1));
        step();
        clearInputs();
        expIrqAck = 1'b0;
        if (haltIn) begin
            mPc = mPc + 16'd1;
        end else if (irqIn) begin
            mEpc = br ? tgt : mPc + 16'd1;
            mPc = IRQV;
            expIrqAck = 1'b1;
        end else if (br) begin
            mPc = tgt;
        end else begin
            mPc = mPc + 16'd1;
        end
        checkVal("retirePc", pc, mPc);
        checkVal("irqAck", irqAck, expIrqAck);
        checkVal("epc", epc, mEpc);
        checkVal("halted", halted, haltIn);
        checkVal("nextReq", imemReq, !haltIn);
        if (expIrqAck) begin
            step();
            checkVal("irqAckPulse", {irqAck, imemReq}, 2'b01);
        end
    endtask

    initial begin
        doReset();

        // Straight-line code from reset, then a branch.
        for (int i = 0; i < 4; i++)
            runInstr(1, 2, 16'($urandom), 1'b0, 16'h0, 1'b0, 1'b0);
        checkVal("pcAfter4", pc, 16'h0004);
        runInstr(1, 2, 16'h1234, 1'b1, 16'h0100, 1'b0, 1'b0);
        checkVal("branchPc", pc, 16'h0100);

        // Interrupt with and without a simultaneous branch.
        runInstr(0, 1, 16'h2222, 1'b1, 16'h0200, 1'b1, 1'b0);
        checkVal("irqEpcBr", epc, 16'h0200);
        runInstr(0, 1, 16'h3333, 1'b0, 16'h0300, 1'b1, 1'b0);
        checkVal("irqEpcSeq", epc, 16'h0011);

        // Wrap from FFFF to 0000.
        runInstr(0, 0, 16'h4444, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        runInstr(0, 0, 16'h5555, 1'b0, 16'h0, 1'b0, 1'b0);
        checkVal("wrapPc", pc, 16'h0000);
        waitReq();

        for (int i = 0; i < 40; i++)
            runInstr($urandom_range(0, TO - 3), $urandom_range(0, 4), 16'($urandom),
                     1'($urandom_range(0, 1)), 16'($urandom),
                     $urandom_range(0, 3) == 0, 1'b0);

        // Ack on the last permitted cycle still completes the fetch.
        runInstr(0, 0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        runInstr(TO - 1, 0, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b0);

        // No ack at all: fault after TO request cycles.
        waitReq();
        for (int i = 1; i < TO; i++) begin
            noise(1'b0, 1'b1);
            step();
            checkVal("toHold", {imemReq, fault}, 2'b10);
        end
        noise(1'b0, 1'b1);
        step();
        checkVal("toFault", {fault, imemReq, instrValid}, 3'b100);
        checkVal("toPc", pc, mPc);
        for (int i = 0; i < 3; i++) begin
            noise(1'b1, 1'b1);
            step();
            checkVal("faultStay", {fault, imemReq, irqAck}, 3'b100);
            checkVal("faultPc", pc, mPc);
        end

        // Reset during a fetch with a late ack.
        doReset();
        waitReq();
        runInstr(0, 0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        waitReq();
        reset_n = 1'b0;
        imemAck = 1'b1;
        step();
        checkVal("midRstReq", imemReq, 0);
        checkVal("midRstPc", pc, 16'h0000);
        reset_n = 1'b1;
        imemAck = 1'b0;
        mPc = 16'h0000;
        mEpc = 16'h0000;
        step();
        checkVal("lateAck", {instrValid, fault}, 2'b00);

        // Halt beats irq and branch.
        runInstr(1, 1, 16'h7777, 1'b0, 16'h0, 1'b0, 1'b0);
        runInstr(1, 1, 16'h8888, 1'b1, 16'h0400, 1'b1, 1'b1);
        checkVal("haltPc", pc, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            noise(1'b1, 1'b1);
            step();
            checkVal("haltStay", {halted, imemReq, irqAck, instrValid}, 4'b1000);
            checkVal("haltPcFrozen", pc, 16'h0002);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered program-counter controller that sequences instruction fetch and execute for the 16-bit core. It owns the PC and drives the instruction-memory read handshake. It hands each fetched instruction to the execute stage, then advances the PC by increment, branch, interrupt vector or halt. It replaces the free-running combinational increment with a clocked, handshake-driven update.

Parameters:
ADDR_W, 16, PC / instruction address width
DATA_W, 16, instruction word width
RESET_PC, 16'h0000, PC value loaded on reset
IRQ_VECTOR, 16'h0010, address jumped to when an interrupt is taken
FETCH_TIMEOUT, 15, max cycles to wait for imemAck before FAULT (must be >= 1)

Ports:
clk  in  1  system clock, all state changes on rising edge
reset_n  in  1  synchronous active-low reset
imemReq  out  1  instruction read request, held until imemAck
imemAddr  out  ADDR_W  read address, equals pc while imemReq=1
imemAck  in  1  memory has returned imemData this cycle
imemData  in  DATA_W  instruction word, valid with imemAck
instrValid  out  1  one-cycle pulse: instrOut holds a new instruction
instrOut  out  DATA_W  latched instruction
execDone  in  1  execute stage finished current instruction
branchTaken  in  1  sampled with execDone: load branchTarget
branchTarget  in  ADDR_W  branch/jump destination
irq  in  1  level interrupt request
irqAck  out  1  one-cycle pulse when interrupt taken
epc  out  ADDR_W  saved return address of last taken interrupt
halt  in  1  sampled with execDone: stop after current instruction
halted  out  1  high in HALT state
fault  out  1  high in FAULT state
pc  out  ADDR_W  current program counter

Behaviour:
- Reset (reset_n=0 at edge): pc=RESET_PC, state=FETCH, timeout counter=0, epc=0, instrOut=0. imemReq, instrValid, irqAck, halted and fault all =0. The first request is asserted in the cycle after reset deasserts. Reset mid-fetch drops imemReq immediately; a late imemAck is ignored.
- States: FETCH, DECODE, EXEC, HALT, FAULT.
- FETCH: imemReq=1, imemAddr=pc, counter increments each cycle.
  - imemAck=1: latch instrOut=imemData, go DECODE, counter=0.
  - Counter reaches FETCH_TIMEOUT without ack: go FAULT. The ack on the timeout cycle itself still wins.
- DECODE: instrValid=1 for exactly this cycle, then EXEC. Fetch-to-instrValid latency is 1 cycle after the ack.
- EXEC: wait for execDone, indefinitely. On execDone, apply these in priority order, then go FETCH unless halting:
  1. halt=1: pc=pc+1, go HALT. This takes precedence over irq and branch.
  2. irq=1: epc = branchTaken ? branchTarget : pc+1; pc=IRQ_VECTOR; irqAck=1 next cycle.
  3. branchTaken=1: pc=branchTarget.
  4. Otherwise: pc=pc+1.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000 with no flag.
- irq is ignored outside EXEC and when execDone=0.
- HALT and FAULT: all request/pulse outputs 0, pc frozen. Exit only via reset.
- Signals sampled outside their qualifying state are ignored: imemAck outside FETCH, execDone outside EXEC.

Decomposition:
- Shared package pc_seq_pkg: state enum (FETCH, DECODE, EXEC, HALT, FAULT), ADDR_W/DATA_W defaults, RESET_PC, IRQ_VECTOR.
- One natural sub-module: pc_next_sel. It is combinational and takes halt, irq, branchTaken, branchTarget and pc. It outputs nextPc, epcLoad and irqTake, encoding the priority and wrap rules.
- The FSM and timeout counter stay in the top module.

Test Plan:
- Reset, ack 1 cycle after each req, execDone 2 cycles after instrValid, no branch, 3 instructions -> imemAddr 0000, 0001, 0002; instrValid one cycle after each ack; pc=0003.
- Branch at pc=0004 with branchTarget=0100 and execDone -> next imemAddr=0100, no irqAck.
- irq=1 and branchTaken=1 (target 0200) together with execDone at pc=0005 -> pc=0010, epc=0200, irqAck pulses one cycle. Repeat with branchTaken=0 -> epc=0006.
- branchTarget=FFFF then plain execDone -> imemAddr FFFF, then 0000.
- Withhold imemAck for 15 cycles with FETCH_TIMEOUT=15 -> fault=1, imemReq=0, pc unchanged. Ack on cycle 15 instead -> normal DECODE.
- halt=1 with execDone (irq also high) -> halted=1, pc=pc+1, no irqAck. Assert reset_n=0 mid-FETCH -> next cycle imemReq=0, pc=0000.
